hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter CNT_WIDTH, default 16; width of the performance counters.
REQ-002 Parameter MAX_WAIT, default 16; the maximum number of consecutive memory-busy cycles allowed before a fault is raised. Range 2..255.
REQ-003 Parameter BOOT_CYCLES, default 2; the number of flush cycles issued after reset release. Range 1..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 mem_busy_i  input  1  data memory not ready; the whole pipeline must hold.
REQ-007 branch_taken_e_i  input  1  branch/jump resolved taken in execute.
REQ-008 load_use_i  input  1  the decode instruction needs the result of a load currently in execute.
REQ-009 en_f_o  output  1  PC register enable.
REQ-010 en_d_o  output  1  fetch/decode pipeline register enable.
REQ-011 flush_d_o  output  1  fetch/decode register synchronous clear.
REQ-012 flush_e_o  output  1  decode/execute register synchronous clear (bubble insert).
REQ-013 fault_o  output  1  sticky memory-timeout fault.
REQ-014 stall_cnt_o  output  CNT_WIDTH  count of cycles with en_d_o=0.
REQ-015 flush_cnt_o  output  CNT_WIDTH  count of cycles with flush_d_o=1 in RUN state.

Function
REQ-016 FSM states SHALL be BOOT, RUN, MEM_WAIT and FAULT; a wait counter (8-bit) and a boot counter (4-bit) SHALL be internal.
REQ-017 BOOT: en_f_o=0, en_d_o=1, flush_d_o=1, flush_e_o=1. The boot counter increments each cycle. After BOOT_CYCLES cycles in BOOT, the next state is RUN.
REQ-018 RUN, mem_busy_i=1: en_f_o=0, en_d_o=0, flush_d_o=0, flush_e_o=0. The wait counter loads 1 and the next state is MEM_WAIT.
REQ-019 RUN, mem_busy_i=0, branch_taken_e_i=1: en_f_o=1, en_d_o=1, flush_d_o=1, flush_e_o=1. Branch takes precedence over load_use_i.
REQ-020 RUN, only load_use_i=1: en_f_o=0, en_d_o=0, flush_d_o=0, flush_e_o=1. This gives a one-cycle stall with a bubble. A sustained load_use_i stalls once per asserted cycle.
REQ-021 RUN, no requests: en_f_o=1, en_d_o=1, flush_d_o=0, flush_e_o=0.
REQ-022 Priority in RUN and MEM_WAIT SHALL be mem_busy_i > branch_taken_e_i > load_use_i.
REQ-023 MEM_WAIT, mem_busy_i=1: the outputs are as in REQ-018. The wait counter increments. When the counter equals MAX_WAIT while still busy, the next state is FAULT.
REQ-024 MEM_WAIT, mem_busy_i=0: the outputs are evaluated exactly as in RUN (REQ-019..021) in the same cycle. The next state is RUN and the wait counter clears.
REQ-025 FAULT: en_f_o=0, en_d_o=0, flush_d_o=1, flush_e_o=1, fault_o=1. Inputs are ignored. Exit is only via reset.
REQ-026 The output signals of REQ-017..025 SHALL be combinational from the current state and inputs. The state, counters and fault_o SHALL be registered.
REQ-027 stall_cnt_o increments on every cycle with en_d_o=0, in any state.
REQ-028 flush_cnt_o increments on every RUN/MEM_WAIT cycle with flush_d_o=1.
REQ-029 Both performance counters SHALL saturate at all-ones and never wrap.
REQ-030 The FSM SHALL never reach any illegal state encoding. Any such encoding SHALL transition to FAULT.

Reset
REQ-031 Asserting rst_n_i=0 SHALL immediately, without a clock, force state=BOOT, both internal counters=0, fault_o=0, stall_cnt_o=0 and flush_cnt_o=0.
REQ-032 While rst_n_i=0, the outputs SHALL be en_f_o=0, en_d_o=1, flush_d_o=1, flush_e_o=1.
REQ-033 Reset asserted mid-MEM_WAIT or in FAULT SHALL behave identically to REQ-031, including clearing the sticky fault.
REQ-034 After release, RUN SHALL be entered after exactly BOOT_CYCLES rising edges.

Verification
REQ-035 Reset release, all inputs 0, BOOT_CYCLES=2 -> 2 cycles with flush_d_o=flush_e_o=1 and en_f_o=0, then en_f_o=en_d_o=1 with both flushes 0; stall_cnt_o=0.
REQ-036 load_use_i=1 for 1 cycle in RUN -> that cycle en_f_o=en_d_o=0 and flush_e_o=1; next cycle normal; stall_cnt_o=1.
REQ-037 branch_taken_e_i=1 and load_use_i=1 in the same cycle -> flush_d_o=flush_e_o=1, en_f_o=1; flush_cnt_o increments by 1, stall_cnt_o unchanged.
REQ-038 mem_busy_i=1 for 5 cycles with branch_taken_e_i=1 held throughout -> 5 cycles with all enables 0 and no flush; on the 6th cycle (busy=0) flush_d_o=1 in the same cycle; stall_cnt_o=5.
REQ-039 mem_busy_i held at 1 with MAX_WAIT=16 -> fault_o=1 after the 16th busy cycle and remains 1 after mem_busy_i drops; rst_n_i pulse low clears it asynchronously.
REQ-040 Preload stall_cnt_o to all-ones via a long stall (CNT_WIDTH=4) -> the value holds at 15 and never wraps.

Source files
------------

// File: rtl/hazard_if.sv
// Pipeline hazard control bundle: memory/branch/load-use requests in,
// stage enables, flushes, fault and performance counters out.
interface hazard_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 mem_busy_i;
    logic                 branch_taken_e_i;
    logic                 load_use_i;
    logic                 en_f_o;
    logic                 en_d_o;
    logic                 flush_d_o;
    logic                 flush_e_o;
    logic                 fault_o;
    logic [CNT_WIDTH-1:0] stall_cnt_o;
    logic [CNT_WIDTH-1:0] flush_cnt_o;

    modport master (
        output mem_busy_i, branch_taken_e_i, load_use_i,
        input  en_f_o, en_d_o, flush_d_o, flush_e_o, fault_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  mem_busy_i, branch_taken_e_i, load_use_i,
        output en_f_o, en_d_o, flush_d_o, flush_e_o, fault_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: boot flush, stall/bubble/flush arbitration,
// memory-wait timeout fault and saturating stall/flush performance counters.
module hazard_controller #(
    parameter int CNT_WIDTH   = 16,
    parameter int MAX_WAIT    = 16,
    parameter int BOOT_CYCLES = 2
) (
    input  logic    clk,
    input  logic    rst_n_i,
    hazard_if.slave hz
);
    typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT, FAULT} state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
    localparam logic [7:0] WAIT_MAX  = 8'(MAX_WAIT);

    state_t               state_q, state_d;
    logic [7:0]           wait_q, wait_d;
    logic [3:0]           boot_q, boot_d;
    logic                 fault_q;
    logic [CNT_WIDTH-1:0] stall_q, flush_q;
    logic                 en_f, en_d, flush_d, flush_e;
    logic                 in_run;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        boot_d  = boot_q;
        en_f    = 1'b0;
        en_d    = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
        case (state_q)
            BOOT: begin
                boot_d = boot_q + 4'd1;
                if (boot_q == BOOT_LAST) state_d = RUN;
            end
            RUN, MEM_WAIT: begin
                if (hz.mem_busy_i) begin
                    en_d    = 1'b0;
                    flush_d = 1'b0;
                    flush_e = 1'b0;
                    // wait_q counts busy cycles, including the one seen in RUN
                    wait_d  = (state_q == RUN) ? 8'd1 : wait_q + 8'd1;
                    state_d = (state_q == MEM_WAIT && wait_d == WAIT_MAX) ? FAULT : MEM_WAIT;
                end else begin
                    state_d = RUN;
                    wait_d  = 8'd0;
                    if (hz.branch_taken_e_i) begin
                        en_f = 1'b1;
                    end else if (hz.load_use_i) begin
                        en_d    = 1'b0;
                        flush_d = 1'b0;
                    end else begin
                        en_f    = 1'b1;
                        flush_d = 1'b0;
                        flush_e = 1'b0;
                    end
                end
            end
            FAULT: en_d = 1'b0;
            default: begin
                en_d    = 1'b0;
                state_d = FAULT;
            end
        endcase
    end

    assign in_run = (state_q == RUN) || (state_q == MEM_WAIT);

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= BOOT;
            wait_q  <= '0;
            boot_q  <= '0;
            fault_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            boot_q  <= boot_d;
            fault_q <= fault_q | (state_d == FAULT);
            if (!en_d && stall_q != '1)            stall_q <= stall_q + 1'b1;
            if (in_run && flush_d && flush_q != '1) flush_q <= flush_q + 1'b1;
        end
    end

    assign hz.en_f_o      = en_f;
    assign hz.en_d_o      = en_d;
    assign hz.flush_d_o   = flush_d;
    assign hz.flush_e_o   = flush_e;
    assign hz.fault_o     = fault_q;
    assign hz.stall_cnt_o = stall_q;
    assign hz.flush_cnt_o = flush_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: a 16-bit-counter and a 4-bit-counter instance
// share stimulus; a rule-level model is compared every cycle, plus literal checks.
module tb_hazard_controller;
    localparam int MAX_WAIT    = 16;
    localparam int BOOT_CYCLES = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy = 1'b0, br_t = 1'b0, lu_t = 1'b0;
    int   errors = 0, checks = 0;

    always #5 clk = ~clk;

    hazard_if #(.CNT_WIDTH(16)) hz16 ();
    hazard_if #(.CNT_WIDTH(4))  hz4 ();

    assign hz16.mem_busy_i = busy;  assign hz4.mem_busy_i = busy;
    assign hz16.branch_taken_e_i = br_t;  assign hz4.branch_taken_e_i = br_t;
    assign hz16.load_use_i = lu_t;  assign hz4.load_use_i = lu_t;

    hazard_controller #(.CNT_WIDTH(16), .MAX_WAIT(MAX_WAIT), .BOOT_CYCLES(BOOT_CYCLES))
        u_big (.clk(clk), .rst_n_i(rst_n), .hz(hz16));
    hazard_controller #(.CNT_WIDTH(4), .MAX_WAIT(MAX_WAIT), .BOOT_CYCLES(BOOT_CYCLES))
        u_small (.clk(clk), .rst_n_i(rst_n), .hz(hz4));

    // Expected {en_f, en_d, flush_d, flush_e} from the request rules.
    function automatic logic [3:0] expect_ctl(input bit in_rst, input bit booting,
                                              input bit flt, input bit b, input bit br,
                                              input bit lu);
        if (in_rst || booting) return 4'b0111;
        if (flt)               return 4'b0011;
        if (b)                 return 4'b0000;
        if (br)                return 4'b1111;
        if (lu)                return 4'b0001;
        return 4'b1100;
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    int         boot_left, run_m, stall_m, flush_m;
    bit         flt_m;
    logic [3:0] ctl_m;

    assign ctl_m = expect_ctl(!rst_n, boot_left != 0, flt_m, busy, br_t, lu_t);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_left <= BOOT_CYCLES;
            run_m     <= 0;
            flt_m     <= 1'b0;
            stall_m   <= 0;
            flush_m   <= 0;
        end else begin
            stall_m <= stall_m + (ctl_m[2] ? 0 : 1);
            flush_m <= flush_m + ((!flt_m && boot_left == 0 && ctl_m[1]) ? 1 : 0);
            if (boot_left > 0) boot_left <= boot_left - 1;
            else if (!flt_m) begin
                if (busy) begin
                    run_m <= run_m + 1;
                    if (run_m + 1 == MAX_WAIT) flt_m <= 1'b1;
                end else run_m <= 0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ctl16();
        return int'({hz16.en_f_o, hz16.en_d_o, hz16.flush_d_o, hz16.flush_e_o});
    endfunction

    always @(negedge clk) begin
        chk("m_ctl16",   ctl16(), int'(ctl_m));
        chk("m_ctl4",    int'({hz4.en_f_o, hz4.en_d_o, hz4.flush_d_o, hz4.flush_e_o}), int'(ctl_m));
        chk("m_fault16", int'(hz16.fault_o), int'(flt_m));
        chk("m_fault4",  int'(hz4.fault_o), int'(flt_m));
        chk("m_stall16", int'(hz16.stall_cnt_o), sat(stall_m, 16));
        chk("m_flush16", int'(hz16.flush_cnt_o), sat(flush_m, 16));
        chk("m_stall4",  int'(hz4.stall_cnt_o), sat(stall_m, 4));
        chk("m_flush4",  int'(hz4.flush_cnt_o), sat(flush_m, 4));
    end

    task automatic cyc(input bit b, input bit br, input bit lu);
        @(posedge clk);
        #2;
        busy = b; br_t = br; lu_t = lu;
        #3;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ctl",   ctl16(), 4'b0111);
        chk("rst_fault", int'(hz16.fault_o), 0);
        chk("rst_stall", int'(hz16.stall_cnt_o), 0);
        chk("rst_stall4", int'(hz4.stall_cnt_o), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        busy = 1'b0; br_t = 1'b0; lu_t = 1'b0;
        #3;
    endtask

    initial begin
        #3;
        chk("por_ctl",   ctl16(), 4'b0111);
        chk("por_flush", int'(hz16.flush_cnt_o), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #3;
        chk("boot1_ctl", ctl16(), 4'b0111);
        cyc(0, 0, 0);
        chk("boot2_ctl", ctl16(), 4'b0111);
        cyc(0, 0, 0);
        chk("run_ctl",   ctl16(), 4'b1100);
        chk("run_stall", int'(hz16.stall_cnt_o), 0);

        cyc(0, 0, 1);
        chk("lu_ctl",    ctl16(), 4'b0001);
        cyc(0, 0, 0);
        chk("lu_after",  ctl16(), 4'b1100);
        chk("lu_stall",  int'(hz16.stall_cnt_o), 1);

        cyc(0, 1, 1);
        chk("brlu_ctl",  ctl16(), 4'b1111);
        cyc(0, 0, 0);
        chk("brlu_flush", int'(hz16.flush_cnt_o), 1);
        chk("brlu_stall", int'(hz16.stall_cnt_o), 1);

        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0);
            chk("busy_ctl", ctl16(), 4'b0000);
        end
        cyc(0, 1, 0);
        chk("busy_end_ctl", ctl16(), 4'b1111);
        cyc(0, 0, 0);
        chk("busy_stall", int'(hz16.stall_cnt_o), 6);
        chk("busy_flush", int'(hz16.flush_cnt_o), 2);

        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1);
            chk("lu_hold_ctl", ctl16(), 4'b0001);
        end
        cyc(0, 0, 0);
        chk("lu_hold_stall", int'(hz16.stall_cnt_o), 9);

        for (int i = 0; i < MAX_WAIT; i++) begin
            cyc(1, 0, 0);
            chk("pre_fault", int'(hz16.fault_o), 0);
        end
        cyc(0, 0, 0);
        chk("fault_set",   int'(hz16.fault_o), 1);
        chk("fault_ctl",   ctl16(), 4'b0011);
        chk("fault_stall", int'(hz16.stall_cnt_o), 25);
        chk("sat_stall4",  int'(hz4.stall_cnt_o), 15);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1);
        chk("fault_sticky", int'(hz16.fault_o), 1);
        chk("sat_hold4",    int'(hz4.stall_cnt_o), 15);
        chk("fault_flush",  int'(hz16.flush_cnt_o), 2);

        reset_pulse();
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("reboot_ctl", ctl16(), 4'b1100);

        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        reset_pulse();
        cyc(0, 0, 0);
        chk("mw_rst_boot", ctl16(), 4'b0111);
        cyc(0, 0, 0);
        chk("mw_rst_run", ctl16(), 4'b1100);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("mw_rst_flush", int'(hz16.flush_cnt_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
